next_line_prefetcher: RTL and testbench
=======================================

Name: next_line_prefetcher

Overview:
- Responder side of the prefetch handshake driven by the prefetch cache controller.
- On a demand miss fill (prefetch_start), captures the miss address and fetches the next sequential cacheline from physical memory through its own arbiter port.
- Buffers that line, then presents it to the cache with prefetch_ready until the controller acknowledges the install.
- Sits between the cache datapath/controller and the pmem arbiter; demand traffic has priority at the arbiter.

Parameters:
ADDR_W, 32, physical address width
OFFSET_W, 5, byte-offset bits per cacheline (32-byte lines)
LINE_W, 256, cacheline data width
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
prefetch_start  in  1  controller is in demand-fill state; level, held for the whole fill
miss_addr  in  ADDR_W  demand miss address; valid while prefetch_start=1
pf_present  in  1  cache lookup of pf_addr hits (combinational from datapath, valid in CHECK)
prefetch_ack  in  1  controller installed the buffered line this cycle
pf_pmem_read  out  1  read request to pmem arbiter
pf_pmem_addr  out  ADDR_W  line-aligned request address
pf_pmem_resp  in  1  arbiter read complete; pf_pmem_rdata valid this cycle
pf_pmem_rdata  in  LINE_W  returned line
prefetch_ready  out  1  buffered line valid for install
pf_addr  out  ADDR_W  line-aligned address of the buffered/pending line; drives tag/index when tag_sel/index_sel=1
pf_line  out  LINE_W  buffered line data
pf_issued  out  CNT_W  saturating count of pmem prefetch reads completed
pf_dropped  out  CNT_W  saturating count of prefetches suppressed or discarded

Behaviour:
- Reset (rst=0, async): state=IDLE; pf_addr=0, pf_line=0, last_addr=0, last_valid=0, counters=0. Outputs forced low: pf_pmem_read=0 and prefetch_ready=0.
- States and transitions:
  - IDLE: on prefetch_start=1, compute nxt={miss_addr[ADDR_W-1:OFFSET_W]+1, OFFSET_W'b0}.
    - If the increment carries out (miss in top line), or last_valid and nxt==last_addr: pf_dropped++, go ARM_DROP.
    - Else latch pf_addr=nxt, go ARM.
  - ARM: wait for prefetch_start=0 so the demand fill has finished; then go FETCH. ARM_DROP: wait for prefetch_start=0, then go IDLE.
  - FETCH: pf_pmem_read=1 and pf_pmem_addr=pf_addr, both held stable until pf_pmem_resp.
    - On resp: pf_line=pf_pmem_rdata, pf_issued++, last_addr=pf_addr, last_valid=1, go CHECK.
  - CHECK (one cycle): if pf_present=1, pf_dropped++ and go IDLE. Else go READY.
  - READY: prefetch_ready=1; pf_addr and pf_line held. On prefetch_ack=1, go IDLE; prefetch_ready is low the next cycle.
- Latency: with zero-wait arbiter, the first pf_pmem_read is 1 cycle after prefetch_start falls. prefetch_ready is 2 cycles after pf_pmem_resp.
- Simultaneous events:
  - prefetch_start rising while in FETCH, CHECK or READY is ignored; no queueing, no counter change.
  - prefetch_ack outside READY is ignored.
  - pf_pmem_resp outside FETCH is ignored.
- Controller handshake:
  - The controller moves to its install state only from checkHit, so prefetch_ready is never asserted while prefetch_start=1.
  - prefetch_ready falls only via prefetch_ack or reset.
- Counters saturate at all-ones and do not wrap.
- Reset mid-FETCH drops the request immediately. The arbiter must tolerate pf_pmem_read falling without resp.
- pf_pmem_addr is always line-aligned (low OFFSET_W bits zero).

Decomposition:
- Shared package pf_types_pkg: state enum (IDLE, ARM, ARM_DROP, FETCH, CHECK, READY), OFFSET_W/LINE_W constants, next-line address function.
- One sub-module, sat_counter (CNT_W, inc, count), instantiated twice for pf_issued/pf_dropped.

Test Plan:
- Basic fetch, arbiter resp after 4 cycles with rdata=256'hA5..A5:
  - Stimulus: prefetch_start high 3 cycles, miss_addr=32'h0000_1044.
  - Required: pf_pmem_addr=32'h0000_1060 after start falls.
  - Then: pf_present=0 gives prefetch_ready=1 with pf_line=A5..A5. Ack drops ready next cycle; pf_issued=1.
- Top-of-memory:
  - Stimulus: miss_addr=32'hFFFF_FFE4.
  - Required: no pf_pmem_read; pf_dropped=1; IDLE after start falls.
- Duplicate filter:
  - Stimulus: two successive misses at 32'h0000_2000 and 32'h0000_2010, both giving next line 0x2020.
  - Required: a single fetch; pf_dropped=1.
- Already present:
  - Stimulus: fetch completes, pf_present=1 in CHECK.
  - Required: prefetch_ready never rises; pf_issued=1, pf_dropped=1.
- Busy ignore and async reset:
  - Stimulus: prefetch_start pulses during FETCH.
  - Required: it is ignored and address is unchanged.
  - Stimulus: rst low mid-FETCH, between clock edges.
  - Required: pf_pmem_read=0 and prefetch_ready=0 immediately, counters=0.
- Counter saturation:
  - Stimulus: force 65536 drops.
  - Required: pf_dropped holds 16'hFFFF.

Source files
------------

// File: rtl/pf_types_pkg.sv
// Shared types and helpers for the next-line prefetcher.
//   - Default widths for address, line offset, line data and counters.
//   - Prefetcher state encoding.
//   - next_line_addr(): line-aligned address of the following cacheline,
//     with the carry-out of the line-number increment in the top bit.
package pf_types_pkg;

  localparam int PF_ADDR_W   = 32;
  localparam int PF_OFFSET_W = 5;
  localparam int PF_LINE_W   = 256;
  localparam int PF_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ARM_DROP,
    FETCH,
    CHECK,
    READY
  } pf_state_e;

  // Result bit PF_ADDR_W is set when the miss sits in the top line of memory,
  // i.e. there is no next line to fetch.
  function automatic logic [PF_ADDR_W:0] next_line_addr(input logic [PF_ADDR_W-1:0] addr);
    logic [PF_ADDR_W-PF_OFFSET_W:0] line_sum;
    line_sum = {1'b0, addr[PF_ADDR_W-1:PF_OFFSET_W]}
             + {{(PF_ADDR_W-PF_OFFSET_W){1'b0}}, 1'b1};
    return {line_sum, {PF_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/next_line_prefetcher_if.sv
// Prefetcher read port towards the physical-memory arbiter.
//   pf_pmem_read  : read request, held until pf_pmem_resp
//   pf_pmem_addr  : line-aligned request address
//   pf_pmem_resp  : read complete, pf_pmem_rdata valid this cycle
//   pf_pmem_rdata : returned cacheline
// master = prefetcher, slave = arbiter.
interface next_line_prefetcher_if
  import pf_types_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int LINE_W = PF_LINE_W
);

  logic              pf_pmem_read;
  logic [ADDR_W-1:0] pf_pmem_addr;
  logic              pf_pmem_resp;
  logic [LINE_W-1:0] pf_pmem_rdata;

  modport master (
    output pf_pmem_read,
    output pf_pmem_addr,
    input  pf_pmem_resp,
    input  pf_pmem_rdata
  );

  modport slave (
    input  pf_pmem_read,
    input  pf_pmem_addr,
    output pf_pmem_resp,
    output pf_pmem_rdata
  );

endinterface

// File: rtl/next_line_prefetcher_sat_counter.sv
// Saturating event counter used for the prefetcher performance counters.
//   clk   : clock
//   rst   : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter
  import pf_types_pkg::*;
#(
  parameter int CNT_W = PF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Stop at all-ones so a long run never wraps back to a small value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher: responder side of the cache controller's prefetch
// handshake. On a demand fill it captures the miss address, fetches the
// following cacheline through its own arbiter port once the demand fill has
// finished, and offers the line to the cache until the controller installs it.
//   clk, rst       : clock, asynchronous active-low reset
//   prefetch_start : controller in demand-fill state (level)
//   miss_addr      : demand miss address, valid with prefetch_start
//   pf_present     : cache lookup of pf_addr hits (sampled in CHECK)
//   prefetch_ack   : controller installed the buffered line
//   pmem           : read port to the pmem arbiter
//   prefetch_ready : buffered line valid for install
//   pf_addr        : line-aligned address of the pending/buffered line
//   pf_line        : buffered line data
//   pf_issued      : saturating count of completed prefetch reads
//   pf_dropped     : saturating count of suppressed/discarded prefetches
module next_line_prefetcher
  import pf_types_pkg::*;
#(
  parameter int ADDR_W   = PF_ADDR_W,
  parameter int OFFSET_W = PF_OFFSET_W,
  parameter int LINE_W   = PF_LINE_W,
  parameter int CNT_W    = PF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prefetch_start,
  input  logic [ADDR_W-1:0]    miss_addr,
  input  logic                 pf_present,
  input  logic                 prefetch_ack,
  next_line_prefetcher_if.master pmem,
  output logic                 prefetch_ready,
  output logic [ADDR_W-1:0]    pf_addr,
  output logic [LINE_W-1:0]    pf_line,
  output logic [CNT_W-1:0]     pf_issued,
  output logic [CNT_W-1:0]     pf_dropped
);

  pf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pf_addr_q;
  logic [LINE_W-1:0] pf_line_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              last_valid_q;

  logic [ADDR_W:0]   nxt_full;
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_carry;
  logic              load_addr;
  logic              load_line;
  logic              issued_inc;
  logic              dropped_inc;
  logic              fetch_active;

  assign nxt_full  = next_line_addr(miss_addr);
  assign nxt_addr  = nxt_full[ADDR_W-1:0];
  assign nxt_carry = nxt_full[ADDR_W];

  // State register plus the captured address/line and the duplicate filter.
  // last_addr remembers the most recently fetched line so a second miss in
  // the same line does not fetch the same next line twice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pf_addr_q    <= '0;
      pf_line_q    <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_addr) begin
        pf_addr_q <= nxt_addr;
      end
      if (load_line) begin
        pf_line_q    <= pmem.pf_pmem_rdata;
        last_addr_q  <= pf_addr_q;
        last_valid_q <= 1'b1;
      end
    end
  end

  // Next-state and output decode. The fetch waits in ARM until the demand
  // fill drops so demand traffic owns the arbiter first. prefetch_start while
  // busy, acks outside READY and responses outside FETCH fall through to the
  // defaults and are therefore ignored.
  always_comb begin
    state_d        = state_q;
    load_addr      = 1'b0;
    load_line      = 1'b0;
    issued_inc     = 1'b0;
    dropped_inc    = 1'b0;
    fetch_active   = 1'b0;
    prefetch_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prefetch_start) begin
          if (nxt_carry || (last_valid_q && (nxt_addr == last_addr_q))) begin
            dropped_inc = 1'b1;
            state_d     = ARM_DROP;
          end else begin
            load_addr = 1'b1;
            state_d   = ARM;
          end
        end
      end
      ARM: begin
        if (!prefetch_start) begin
          state_d = FETCH;
        end
      end
      ARM_DROP: begin
        if (!prefetch_start) begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        fetch_active = 1'b1;
        if (pmem.pf_pmem_resp) begin
          load_line  = 1'b1;
          issued_inc = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (pf_present) begin
          dropped_inc = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = READY;
        end
      end
      READY: begin
        prefetch_ready = 1'b1;
        if (prefetch_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pmem.pf_pmem_read = fetch_active;
  assign pmem.pf_pmem_addr = {pf_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign pf_addr           = pf_addr_q;
  assign pf_line           = pf_line_q;

  sat_counter #(.CNT_W(CNT_W)) u_issued_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (issued_inc),
    .count (pf_issued)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dropped_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dropped_inc),
    .count (pf_dropped)
  );

endmodule

// File: tb/tb_next_line_prefetcher.sv
// Self-checking bench for next_line_prefetcher.
// Inputs are driven and outputs sampled on the falling clock edge.
// A second instance with 8-bit counters exercises counter saturation.
module tb_next_line_prefetcher;

  logic         clk;
  logic         rst;
  logic         prefetch_start;
  logic [31:0]  miss_addr;
  logic         pf_present;
  logic         prefetch_ack;
  logic         prefetch_ready;
  logic [31:0]  pf_addr;
  logic [255:0] pf_line;
  logic [15:0]  pf_issued;
  logic [15:0]  pf_dropped;

  logic         sat_start;
  logic [31:0]  sat_miss;
  logic         sat_ready;
  logic [31:0]  sat_pf_addr;
  logic [255:0] sat_pf_line;
  logic [7:0]   sat_issued;
  logic [7:0]   sat_dropped;

  int n_checks;
  int n_pass;
  int exp_issued;
  int exp_dropped;

  next_line_prefetcher_if pmem_bus ();
  next_line_prefetcher_if sat_bus ();

  assign sat_bus.pf_pmem_resp  = 1'b0;
  assign sat_bus.pf_pmem_rdata = '0;

  next_line_prefetcher dut (
    .clk            (clk),
    .rst            (rst),
    .prefetch_start (prefetch_start),
    .miss_addr      (miss_addr),
    .pf_present     (pf_present),
    .prefetch_ack   (prefetch_ack),
    .pmem           (pmem_bus.master),
    .prefetch_ready (prefetch_ready),
    .pf_addr        (pf_addr),
    .pf_line        (pf_line),
    .pf_issued      (pf_issued),
    .pf_dropped     (pf_dropped)
  );

  next_line_prefetcher #(.CNT_W(8)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .prefetch_start (sat_start),
    .miss_addr      (sat_miss),
    .pf_present     (1'b0),
    .prefetch_ack   (1'b0),
    .pmem           (sat_bus.master),
    .prefetch_ready (sat_ready),
    .pf_addr        (sat_pf_addr),
    .pf_line        (sat_pf_line),
    .pf_issued      (sat_issued),
    .pf_dropped     (sat_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  miss;
    logic         drop;
    logic [31:0]  exp_addr;
    logic [255:0] rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_reset();
    rst                    = 1'b0;
    prefetch_start         = 1'b0;
    miss_addr              = '0;
    pf_present             = 1'b0;
    prefetch_ack           = 1'b0;
    pmem_bus.pf_pmem_resp  = 1'b0;
    pmem_bus.pf_pmem_rdata = '0;
    sat_start              = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Holds prefetch_start for 'hold' cycles, returns at the falling edge
  // where it drops.
  task automatic start_miss(input logic [31:0] addr, input int hold);
    prefetch_start = 1'b1;
    miss_addr      = addr;
    repeat (hold) @(negedge clk);
    prefetch_start = 1'b0;
  endtask

  // One-cycle response, then the CHECK cycle with the given lookup result.
  task automatic respond(input logic [255:0] data, input logic present, input string tag);
    pmem_bus.pf_pmem_resp  = 1'b1;
    pmem_bus.pf_pmem_rdata = data;
    @(negedge clk);
    pmem_bus.pf_pmem_resp  = 1'b0;
    pmem_bus.pf_pmem_rdata = '0;
    pf_present             = present;
    check_output({tag, "_no_ready_in_check"}, prefetch_ready, 1'b0);
    @(negedge clk);
    pf_present = 1'b0;
  endtask

  // Expects the read one cycle after start fell, holds it 'delay' cycles.
  task automatic fetch_and_respond(input logic [31:0] addr, input int delay,
                                   input logic [255:0] data, input logic present,
                                   input string tag);
    @(negedge clk);
    check_output({tag, "_first_read"}, {pmem_bus.pf_pmem_read, pmem_bus.pf_pmem_addr},
                 {1'b1, addr});
    repeat (delay - 1) @(negedge clk);
    check_output({tag, "_read_held"}, {pmem_bus.pf_pmem_read, pmem_bus.pf_pmem_addr},
                 {1'b1, addr});
    respond(data, present, tag);
  endtask

  task automatic ack_line(input string tag);
    prefetch_ack = 1'b1;
    @(negedge clk);
    prefetch_ack = 1'b0;
    check_output({tag, "_ready_after_ack"}, prefetch_ready, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    sat_miss = 32'hFFFF_FFE4;

    vecs[0] = '{32'h0000_1044, 1'b0, 32'h0000_1060, {32{8'hA5}}};
    vecs[1] = '{32'h0000_1060, 1'b0, 32'h0000_1080, {8{32'hDEAD_BEEF}}};
    vecs[2] = '{32'h0000_107F, 1'b1, 32'h0000_0000, '0};
    vecs[3] = '{32'hFFFF_FFE4, 1'b1, 32'h0000_0000, '0};
    vecs[4] = '{32'h8000_001F, 1'b0, 32'h8000_0020, {16{16'h1234}}};
    vecs[5] = '{32'hFFFF_FFDF, 1'b0, 32'hFFFF_FFE0, {64{4'h7}}};
    vecs[6] = '{32'h0000_0000, 1'b0, 32'h0000_0020, {4{64'h0123_4567_89AB_CDEF}}};

    // Reset state
    apply_reset();
    check_output("rst_read",    pmem_bus.pf_pmem_read, 1'b0);
    check_output("rst_ready",   prefetch_ready, 1'b0);
    check_output("rst_pf_addr", pf_addr, 32'h0);
    check_output("rst_pf_line", pf_line, 256'h0);
    check_output("rst_issued",  pf_issued, 16'h0);
    check_output("rst_dropped", pf_dropped, 16'h0);

    // Table of back-to-back misses; counters accumulate across entries
    exp_issued  = 0;
    exp_dropped = 0;
    for (int i = 0; i < 7; i++) begin
      start_miss(vecs[i].miss, 3);
      check_output($sformatf("v%0d_read_during_start", i), pmem_bus.pf_pmem_read, 1'b0);
      if (vecs[i].drop) begin
        exp_dropped++;
        @(negedge clk);
        check_output($sformatf("v%0d_no_fetch", i), pmem_bus.pf_pmem_read, 1'b0);
        @(negedge clk);
        check_output($sformatf("v%0d_dropped", i), pf_dropped, exp_dropped[15:0]);
        check_output($sformatf("v%0d_issued", i), pf_issued, exp_issued[15:0]);
      end else begin
        exp_issued++;
        fetch_and_respond(vecs[i].exp_addr, 4, vecs[i].rdata, 1'b0, $sformatf("v%0d", i));
        check_output($sformatf("v%0d_ready", i), prefetch_ready, 1'b1);
        check_output($sformatf("v%0d_line", i), pf_line, vecs[i].rdata);
        check_output($sformatf("v%0d_pf_addr", i), pf_addr, vecs[i].exp_addr);
        check_output($sformatf("v%0d_issued", i), pf_issued, exp_issued[15:0]);
        ack_line($sformatf("v%0d", i));
        check_output($sformatf("v%0d_dropped", i), pf_dropped, exp_dropped[15:0]);
      end
    end

    // Duplicate filter: two misses in line 0x2000 share next line 0x2020
    apply_reset();
    start_miss(32'h0000_2000, 3);
    fetch_and_respond(32'h0000_2020, 1, {32{8'h3C}}, 1'b0, "dup1");
    check_output("dup1_ready", prefetch_ready, 1'b1);
    ack_line("dup1");
    start_miss(32'h0000_2010, 3);
    @(negedge clk);
    check_output("dup2_no_fetch", pmem_bus.pf_pmem_read, 1'b0);
    @(negedge clk);
    check_output("dup2_no_fetch_later", pmem_bus.pf_pmem_read, 1'b0);
    check_output("dup_issued",  pf_issued, 16'd1);
    check_output("dup_dropped", pf_dropped, 16'd1);

    // Line already in the cache when the fetch lands
    apply_reset();
    start_miss(32'h0000_6000, 3);
    fetch_and_respond(32'h0000_6020, 2, {32{8'h96}}, 1'b1, "present");
    check_output("present_no_ready", prefetch_ready, 1'b0);
    @(negedge clk);
    check_output("present_no_ready_later", prefetch_ready, 1'b0);
    check_output("present_issued",  pf_issued, 16'd1);
    check_output("present_dropped", pf_dropped, 16'd1);

    // prefetch_start pulse while fetching is ignored
    apply_reset();
    start_miss(32'h0000_3000, 2);
    @(negedge clk);
    check_output("busy_first_read", {pmem_bus.pf_pmem_read, pmem_bus.pf_pmem_addr},
                 {1'b1, 32'h0000_3020});
    prefetch_start = 1'b1;
    miss_addr      = 32'h0000_5000;
    @(negedge clk);
    prefetch_start = 1'b0;
    @(negedge clk);
    check_output("busy_addr_kept", {pmem_bus.pf_pmem_read, pmem_bus.pf_pmem_addr},
                 {1'b1, 32'h0000_3020});
    check_output("busy_pf_addr", pf_addr, 32'h0000_3020);
    respond({8{32'hCAFE_F00D}}, 1'b0, "busy");
    check_output("busy_ready", prefetch_ready, 1'b1);
    ack_line("busy");
    check_output("busy_issued",  pf_issued, 16'd1);
    check_output("busy_dropped", pf_dropped, 16'd0);

    // Asynchronous reset in the middle of a fetch
    start_miss(32'h0000_4000, 2);
    @(negedge clk);
    check_output("arst_pre_read", pmem_bus.pf_pmem_read, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_read",    pmem_bus.pf_pmem_read, 1'b0);
    check_output("arst_ready",   prefetch_ready, 1'b0);
    check_output("arst_issued",  pf_issued, 16'd0);
    check_output("arst_dropped", pf_dropped, 16'd0);
    check_output("arst_pf_addr", pf_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("arst_stays_idle", pmem_bus.pf_pmem_read, 1'b0);

    // Counter saturation on the narrow-counter instance
    apply_reset();
    for (int i = 0; i < 254; i++) begin
      sat_start = 1'b1;
      @(negedge clk);
      sat_start = 1'b0;
      @(negedge clk);
    end
    check_output("sat_count_254", sat_dropped, 8'hFE);
    for (int i = 0; i < 46; i++) begin
      sat_start = 1'b1;
      @(negedge clk);
      sat_start = 1'b0;
      @(negedge clk);
    end
    check_output("sat_held_ff", sat_dropped, 8'hFF);
    check_output("sat_issued",  sat_issued, 8'h00);
    check_output("sat_no_read", sat_bus.pf_pmem_read, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
